div_ctrl: RTL



---
 rtl/div_ctrl.sv | 87 ++++++++
 1 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: 32-step restoring divider controller for MIPS DIV/DIVU; optional macro DIV_ZERO_FAST_EN adds a fast zero-divisor path
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stall_o
);
`ifdef DIV_ZERO_FAST_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DIV_ZERO = 2'd1, ON = 2'd2, END = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd2, END = 2'd3} state_t;
`endif
    state_t      state, next;
    logic [4:0]  cnt;
    logic [64:0] w, w_nxt;
    logic [31:0] dvs, mag1, mag2, quo, rem;
    logic [32:0] diff;
    logic        sgn, s1, s2, accept;
    assign accept  = start_i & ~annul_i;
    assign mag1    = (signed_i & opdata1_i[31]) ? -opdata1_i : opdata1_i;
    assign mag2    = (signed_i & opdata2_i[31]) ? -opdata2_i : opdata2_i;
    assign diff    = {1'b0, w[63:32]} - {1'b0, dvs};
    assign w_nxt   = diff[32] ? {w[63:0], 1'b0} : {diff[31:0], w[31:0], 1'b1};
    assign quo     = w_nxt[31:0];
    assign rem     = w_nxt[64:33];
    assign ready_o = state == END;
    assign stall_o = start_i & ~ready_o;
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end
    // next-state logic; annul_i overrides start_i everywhere
    always_comb begin
        next = state;
        case (state)
`ifdef DIV_ZERO_FAST_EN
            IDLE:     next = accept ? ((opdata2_i == 32'd0) ? DIV_ZERO : ON) : IDLE;
            DIV_ZERO: next = annul_i ? IDLE : END;
`else
            IDLE:     next = accept ? ON : IDLE;
`endif
            ON:       next = annul_i ? IDLE : ((cnt == 5'd31) ? END : ON);
            END:      next = (annul_i | ~start_i) ? IDLE : END;
            default:  next = IDLE;
        endcase
    end
    // operand capture, divide steps and sign-corrected result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 5'd0;
            w        <= 65'd0;
            dvs      <= 32'd0;
            sgn      <= 1'b0;
            s1       <= 1'b0;
            s2       <= 1'b0;
            result_o <= 64'd0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    w   <= {32'd0, mag1, 1'b0};
                    dvs <= mag2;
                    sgn <= signed_i;
                    s1  <= opdata1_i[31];
                    s2  <= opdata2_i[31];
                    cnt <= 5'd0;
                end
`ifdef DIV_ZERO_FAST_EN
                DIV_ZERO: if (!annul_i) result_o <= 64'd0;
`endif
                ON: if (!annul_i) begin
                    w   <= w_nxt;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        result_o <= {(sgn & s1) ? -rem : rem, (sgn & (s1 ^ s2)) ? -quo : quo};
                end
                default: ;
            endcase
        end
    end
endmodule
